// File: rtl/temp_cmd_pkg.sv
// Shared definitions for the temperature command controller: opcodes,
// reply fill bytes, FSM state encoding and small arithmetic helpers.
package temp_cmd_pkg;

    localparam logic [7:0] OP_READ_TEMP = 8'h01;
    localparam logic [7:0] OP_SET_HI    = 8'h02;
    localparam logic [7:0] OP_SET_LO    = 8'h03;
    localparam logic [7:0] OP_READ_CFG  = 8'h04;

    localparam logic [7:0] ERR_BYTE     = 8'hEE;
    localparam logic [7:0] TO_FILL_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_GET_ARG     = 3'd1,
        S_EXEC        = 3'd2,
        S_SENSOR_WAIT = 3'd3,
        S_TX          = 3'd4
    } state_t;

    // Saturating 8-bit add of a small increment; sticks at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, inc};
        if (s[8]) begin
            return 8'hFF;
        end else begin
            return s[7:0];
        end
    endfunction

    // True for the four opcodes the controller executes.
    function automatic logic is_known_op(input logic [7:0] op);
        case (op)
            OP_READ_TEMP, OP_SET_HI, OP_SET_LO, OP_READ_CFG: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cmd_reply_tx.sv
// Two-byte reply holding register. A load pulse captures 16 bits; the high
// byte is presented first on a valid/ready interface, then the low byte.
// o_done flags the cycle in which the last byte is accepted.
module cmd_reply_tx
    import temp_cmd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [15:0] i_data,
    input  logic        i_rdy,
    output logic [7:0]  o_data,
    output logic        o_vld,
    output logic        o_done
);

    logic [7:0] r_data;
    logic [7:0] r_lo;
    logic       r_vld;
    logic       r_idx;

    // Load the reply, then shift to the low byte on each accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= 8'h00;
            r_lo   <= 8'h00;
            r_vld  <= 1'b0;
            r_idx  <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data[15:8];
            r_lo   <= i_data[7:0];
            r_vld  <= 1'b1;
            r_idx  <= 1'b0;
        end else if (r_vld && i_rdy) begin
            if (!r_idx) begin
                r_data <= r_lo;
                r_idx  <= 1'b1;
            end else begin
                r_vld  <= 1'b0;
                r_idx  <= 1'b0;
            end
        end else begin
            r_data <= r_data;
        end
    end

    assign o_data = r_data;
    assign o_vld  = r_vld;
    assign o_done = r_vld && i_rdy && r_idx;

endmodule

// File: rtl/temp_cmd_ctrl.sv
// Temperature monitor command sequencer. Takes opcode/argument byte pairs,
// updates alarm thresholds, reads back configuration or samples the sensor,
// and returns a 2-byte reply through cmd_reply_tx.
// Optional feature macro CMD_ERR_REPLY_EN: when defined, unknown opcodes
// produce the reply {8'hEE, opcode}; otherwise they are silently dropped.
module temp_cmd_ctrl
    import temp_cmd_pkg::*;
#(
    parameter int         TIMEOUT    = 50000,
    parameter logic [7:0] THR_HI_RST = 8'd60,
    parameter logic [7:0] THR_LO_RST = 8'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  op_byte,
    input  logic        op_byte_vld,
    output logic        sensor_req,
    input  logic        sensor_ack,
    input  logic [15:0] sensor_data,
    output logic [7:0]  tx_data,
    output logic        tx_vld,
    input  logic        tx_rdy,
    output logic [7:0]  thr_hi,
    output logic [7:0]  thr_lo,
    output logic [7:0]  drop_cnt
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

`ifdef CMD_ERR_REPLY_EN
    localparam logic ERR_REPLY_EN = 1'b1;
`else
    localparam logic ERR_REPLY_EN = 1'b0;
`endif

    state_t        r_state;
    logic [7:0]    r_opcode;
    logic [7:0]    r_arg;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_thr_hi;
    logic [7:0]    r_thr_lo;
    logic [7:0]    r_drop_cnt;
    logic          r_sensor_req;

    logic          w_timeout;
    logic          w_load;
    logic [15:0]   w_reply;
    logic          w_done;
    logic [1:0]    w_drop_inc;

    assign w_timeout = (r_timer == T_LAST);

    // Select the reply to load into the transmitter and when to load it.
    always_comb begin
        w_load  = 1'b0;
        w_reply = 16'h0000;
        case (r_state)
            S_EXEC: begin
                if (r_opcode == OP_READ_CFG) begin
                    w_load  = 1'b1;
                    w_reply = {r_thr_hi, r_thr_lo};
                end else if (ERR_REPLY_EN && !is_known_op(r_opcode)) begin
                    w_load  = 1'b1;
                    w_reply = {ERR_BYTE, r_opcode};
                end else begin
                    w_load  = 1'b0;
                end
            end
            S_SENSOR_WAIT: begin
                if (sensor_ack) begin
                    w_load  = 1'b1;
                    w_reply = sensor_data;
                end else if (w_timeout) begin
                    w_load  = 1'b1;
                    w_reply = {TO_FILL_BYTE, TO_FILL_BYTE};
                end else begin
                    w_load  = 1'b0;
                end
            end
            default: begin
                w_load  = 1'b0;
            end
        endcase
    end

    // Count this cycle's dropped events: discarded bytes, unknown opcodes,
    // and frames abandoned for lack of an argument byte.
    always_comb begin
        w_drop_inc = 2'd0;
        if (op_byte_vld && (r_state == S_EXEC || r_state == S_SENSOR_WAIT || r_state == S_TX)) begin
            w_drop_inc = w_drop_inc + 2'd1;
        end else begin
            w_drop_inc = w_drop_inc;
        end
        if (r_state == S_EXEC && !is_known_op(r_opcode)) begin
            w_drop_inc = w_drop_inc + 2'd1;
        end else if (r_state == S_GET_ARG && !op_byte_vld && w_timeout) begin
            w_drop_inc = w_drop_inc + 2'd1;
        end else begin
            w_drop_inc = w_drop_inc;
        end
    end

    // Command sequencer: frame capture, execution, sensor handshake and reply wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_opcode     <= 8'h00;
            r_arg        <= 8'h00;
            r_timer      <= '0;
            r_thr_hi     <= THR_HI_RST;
            r_thr_lo     <= THR_LO_RST;
            r_drop_cnt   <= 8'h00;
            r_sensor_req <= 1'b0;
        end else begin
            r_drop_cnt <= sat_add8(r_drop_cnt, w_drop_inc);
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (op_byte_vld) begin
                        r_opcode <= op_byte;
                        r_state  <= S_GET_ARG;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_GET_ARG: begin
                    if (op_byte_vld) begin
                        r_arg   <= op_byte;
                        r_timer <= '0;
                        r_state <= S_EXEC;
                    end else if (w_timeout) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_EXEC: begin
                    r_timer <= '0;
                    case (r_opcode)
                        OP_READ_TEMP: begin
                            r_sensor_req <= 1'b1;
                            r_state      <= S_SENSOR_WAIT;
                        end
                        OP_SET_HI: begin
                            r_thr_hi <= r_arg;
                            r_state  <= S_IDLE;
                        end
                        OP_SET_LO: begin
                            r_thr_lo <= r_arg;
                            r_state  <= S_IDLE;
                        end
                        OP_READ_CFG: begin
                            r_state <= S_TX;
                        end
                        default: begin
                            r_state <= ERR_REPLY_EN ? S_TX : S_IDLE;
                        end
                    endcase
                end
                S_SENSOR_WAIT: begin
                    if (sensor_ack || w_timeout) begin
                        r_sensor_req <= 1'b0;
                        r_timer      <= '0;
                        r_state      <= S_TX;
                    end else begin
                        r_timer      <= r_timer + TW'(1);
                    end
                end
                S_TX: begin
                    r_timer <= '0;
                    if (w_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_TX;
                    end
                end
                default: begin
                    r_timer      <= '0;
                    r_sensor_req <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    cmd_reply_tx u_reply_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_data (w_reply),
        .i_rdy  (tx_rdy),
        .o_data (tx_data),
        .o_vld  (tx_vld),
        .o_done (w_done)
    );

    assign sensor_req = r_sensor_req;
    assign thr_hi     = r_thr_hi;
    assign thr_lo     = r_thr_lo;
    assign drop_cnt   = r_drop_cnt;

endmodule
